// File: rtl/sp_ram_ctrl_pkg.sv
// Shared types and defaults for the single-port data RAM request front end.
package sp_ram_ctrl_pkg;

  localparam int unsigned RSP_DATA_W    = 32;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0010_0000;
  localparam int unsigned DEF_RSP_DEPTH = 2;

  // One response as seen by the requester: read data (zero for writes/errors)
  // plus the out-of-window error flag.
  typedef struct packed {
    logic [RSP_DATA_W-1:0] rdata;
    logic                  err;
  } rsp_t;

endpackage

// File: rtl/sp_ram_rsp_fifo.sv
// Small synchronous response FIFO holding rsp_t entries in arrival order.
module sp_ram_rsp_fifo
  import sp_ram_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_RSP_DEPTH
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push,
  input  logic                         pop,
  input  rsp_t                         wdata,
  output rsp_t                         rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  rsp_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);
  assign count  = cnt;
  assign do_pop = pop & ~empty;
  assign rdata  = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave cnt unchanged.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= bump(wr_ptr);
      if (do_pop) rd_ptr <= bump(rd_ptr);
      case ({push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents need no reset since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  a_cnt_bound : assert property (@(posedge clk) disable iff (!rstn) cnt <= CW'(DEPTH));
  a_no_ovf    : assert property (@(posedge clk) disable iff (!rstn) push |-> !full);

endmodule

// File: rtl/sp_ram_req_ctrl.sv
// Request/grant front end for the banked single-port data RAM wrapper:
// window decode, credit-based grant, one-cycle pending stage and an
// in-order response FIFO absorbing requester backpressure.
module sp_ram_req_ctrl
  import sp_ram_ctrl_pkg::*;
#(
  parameter int unsigned RAM_SIZE   = 32768,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int unsigned DATA_WIDTH = RSP_DATA_W,
  parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter int unsigned RSP_DEPTH  = DEF_RSP_DEPTH
) (
  input  logic                    clk,
  input  logic                    rstn_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [31:0]             addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic                    ram_en_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned UW = CW + 1;

  logic          hit;
  logic          accept;
  logic          pop;
  logic          space;
  logic [UW-1:0] used;
  logic          pend_q;
  logic          pend_we_q;
  logic          pend_err_q;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_full;
  logic          fifo_empty;
  rsp_t          push_rsp;
  rsp_t          head_rsp;

  assign hit = (addr_i[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
  assign pop = rvalid_o & rready_i;

  // Credit check: entries queued plus the one in flight, minus what leaves this cycle.
  always_comb begin
    used  = '0;
    used  = {1'b0, fifo_cnt} + UW'(pend_q) - UW'(pop);
    space = (used < UW'(RSP_DEPTH));
  end

  // Grant and RAM drive are purely combinational so the RAM sees the access in the grant cycle.
  always_comb begin
    gnt_o       = rstn_i & req_i & space;
    accept      = req_i & gnt_o;
    ram_en_o    = accept & hit;
    ram_we_o    = we_i;
    ram_be_o    = we_i ? be_i : '1;
    ram_addr_o  = addr_i[ADDR_WIDTH-1:0];
    ram_wdata_o = wdata_i;
  end

  // Pending stage tracks the access whose RAM data arrives next cycle.
  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      pend_q     <= 1'b0;
      pend_we_q  <= 1'b0;
      pend_err_q <= 1'b0;
    end else begin
      pend_q <= accept;
      if (accept) begin
        pend_we_q  <= we_i;
        pend_err_q <= ~hit;
      end
    end
  end

  // Build the response entry; writes and errors return zero data.
  always_comb begin
    push_rsp       = '0;
    push_rsp.rdata = (pend_we_q | pend_err_q) ? '0 : ram_rdata_i;
    push_rsp.err   = pend_err_q;
  end

  sp_ram_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rstn  (rstn_i),
    .push  (pend_q),
    .pop   (pop),
    .wdata (push_rsp),
    .rdata (head_rsp),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign rvalid_o = ~fifo_empty;
  assign rdata_o  = head_rsp.rdata;
  assign err_o    = head_rsp.err;

  a_rsp_hold : assert property (@(posedge clk) disable iff (!rstn_i)
    (rvalid_o && !rready_i) |=> (rvalid_o && $stable(rdata_o) && $stable(err_o)));
  a_credit   : assert property (@(posedge clk) disable iff (!rstn_i)
    pend_q |-> !fifo_full);

endmodule

// File: tb/tb_sp_ram_req_ctrl.sv
// Scoreboard bench for sp_ram_req_ctrl with a behavioural 1-cycle RAM.
module tb_sp_ram_req_ctrl;

  localparam logic [31:0] BASE = 32'h0010_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic        rready = 1'b0;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        ram_en;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [14:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;

  sp_ram_req_ctrl #(
    .RAM_SIZE   (32768),
    .DATA_WIDTH (32),
    .BASE_ADDR  (BASE),
    .RSP_DEPTH  (2)
  ) dut (
    .clk         (clk),
    .rstn_i      (rstn),
    .req_i       (req),
    .gnt_o       (gnt),
    .addr_i      (addr),
    .we_i        (we),
    .be_i        (be),
    .wdata_i     (wdata),
    .rvalid_o    (rvalid),
    .rready_i    (rready),
    .rdata_o     (rdata),
    .err_o       (err),
    .ram_en_o    (ram_en),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM wrapper: byte-enabled writes, read data one cycle after enable.
  logic [31:0] mem [8192];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr[14:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr[14:2]];
      end
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned lat;
    int unsigned acc_cyc;
    string       tag;
  } exp_t;

  exp_t        sbq[$];
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  int unsigned en_cnt = 0;
  int unsigned pops = 0;
  int unsigned grants = 0;
  int unsigned last_acc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
    end
  endtask

  // Monitor: every handshaken response is popped from the scoreboard and compared.
  always @(negedge clk) begin
    exp_t e;
    if (ram_en) en_cnt++;
    if (rstn && rvalid && rready) begin
      pops++;
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rvalid=1 rdata=0x%08h expected no response", rdata);
      end else begin
        e = sbq.pop_front();
        check({e.tag, "_rdata"}, rdata, e.rdata);
        check({e.tag, "_err"}, 32'(err), 32'(e.err));
        if (e.lat != 0) check({e.tag, "_lat"}, 32'(cyc - e.acc_cyc), 32'(e.lat));
      end
    end
  end

  task automatic issue(input string tag, input logic [31:0] a, input logic w,
                       input logic [3:0] b, input logic [31:0] d,
                       input logic [31:0] er, input logic ee, input int unsigned lat);
    int unsigned n;
    logic        done;
    exp_t        e;
    n = 0;
    done = 1'b0;
    req = 1'b1; addr = a; we = w; be = b; wdata = d;
    while (!done) begin
      @(negedge clk);
      if (gnt) begin
        e.rdata = er; e.err = ee; e.lat = lat; e.acc_cyc = cyc; e.tag = tag;
        sbq.push_back(e);
        grants++;
        last_acc = cyc;
        done = 1'b1;
      end else if (++n > 50) begin
        total++;
        bad++;
        $display("FAIL %s_grant_timeout: got no gnt expected gnt within 50 cycles", tag);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 32'(sbq.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int unsigned g0;
    int unsigned e0;
    int unsigned p0;
    int unsigned first_acc;

    // Reset: grants and RAM enable forced low even with a request present.
    req = 1'b1; addr = BASE;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_en", 32'(ram_en), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1; req = 1'b0; rready = 1'b1;

    // Read after write with 2-cycle latency.
    issue("raw_wr", 32'h0010_0040, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
    issue("raw_rd", 32'h0010_0040, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
    drain();

    // Byte enables, including a null write.
    issue("be_wr0", 32'h0010_0080, 1'b1, 4'hF, 32'h1122_3344, 32'h0, 1'b0, 0);
    issue("be_wr1", 32'h0010_0080, 1'b1, 4'b0101, 32'hAAAA_AAAA, 32'h0, 1'b0, 0);
    issue("be_rd", 32'h0010_0080, 1'b0, 4'hF, 32'h0, 32'h11AA_33AA, 1'b0, 0);
    issue("be_null", 32'h0010_0080, 1'b1, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0, 0);
    issue("be_rd2", 32'h0010_0081, 1'b0, 4'hF, 32'h0, 32'h11AA_33AA, 1'b0, 0);
    drain();

    // Backpressure: two grants fill the credits, then grants stop.
    rready = 1'b0;
    g0 = grants;
    issue("bp_a", 32'h0010_0040, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
    issue("bp_b", 32'h0010_0080, 1'b0, 4'hF, 32'h0, 32'h11AA_33AA, 1'b0, 0);
    req = 1'b1; addr = 32'h0010_0040; we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_gnt_stop", 32'(gnt), 32'd0);
      @(posedge clk); #1;
    end
    check("bp_grants", 32'(grants - g0), 32'd2);
    @(negedge clk);
    check("bp_head_valid", 32'(rvalid), 32'd1);
    check("bp_head_data", rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    rready = 1'b1;
    issue("bp_c", 32'h0010_0040, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
    issue("bp_d", 32'h0010_0080, 1'b0, 4'hF, 32'h0, 32'h11AA_33AA, 1'b0, 0);
    drain();

    // Streaming: fill 16 words, then read them back one per cycle.
    for (int i = 0; i < 16; i++)
      issue("st_wr", 32'h0010_0100 + 32'(4*i), 1'b1, 4'hF, 32'hC0DE_0000 + 32'(i * 32'h111),
            32'h0, 1'b0, 0);
    drain();
    p0 = pops;
    first_acc = 0;
    for (int i = 0; i < 16; i++) begin
      issue("st_rd", 32'h0010_0100 + 32'(4*i), 1'b0, 4'hF, 32'h0,
            32'hC0DE_0000 + 32'(i * 32'h111), 1'b0, 0);
      if (i == 0) first_acc = last_acc;
    end
    check("st_span", 32'(last_acc - first_acc), 32'd15);
    drain();
    check("st_pops", 32'(pops - p0), 32'd16);

    // Out of window: granted, no RAM access, error response.
    e0 = en_cnt;
    issue("oow", 32'h0020_0000, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 2);
    drain();
    check("oow_en", 32'(en_cnt - e0), 32'd0);

    // Reset with one response queued and one in flight: everything discarded.
    rready = 1'b0;
    issue("mr_a", 32'h0010_0040, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
    issue("mr_b", 32'h0010_0080, 1'b0, 4'hF, 32'h0, 32'h11AA_33AA, 1'b0, 0);
    rstn = 1'b0; req = 1'b1; addr = 32'h0010_0040; we = 1'b0;
    @(negedge clk);
    check("mr_gnt", 32'(gnt), 32'd0);
    check("mr_en", 32'(ram_en), 32'd0);
    @(posedge clk); #1;
    sbq.delete();
    @(negedge clk);
    check("mr_rvalid", 32'(rvalid), 32'd0);
    check("mr_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1; req = 1'b0; rready = 1'b1;
    issue("mr_fresh", 32'h0010_0080, 1'b0, 4'hF, 32'h0, 32'h11AA_33AA, 1'b0, 2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
